// File: rtl/rf_pkg.sv
// Shared constants and helpers for the ring-of-banks register file.
// The error bit positions and lane slicing are defined once here and reused by every file.
package rf_pkg;

    localparam int ERR_WR = 0;
    localparam int ERR_RD = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int lane_lsb(input int lane, input int data_bitwidth);
        return lane * data_bitwidth;
    endfunction

endpackage

// File: rtl/rf_bank.sv
// One register-file bank: DEPTH rows of LANES words each.
// Writes are masked per lane and synchronous; the read path is a plain mux, and the top level registers it.
module rf_bank
    import rf_pkg::*;
#(
    parameter int DATA_BITWIDTH = 8,
    parameter int LANES         = 2,
    parameter int DEPTH         = 4,
    parameter int ADDR_BITWIDTH = 2
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [ADDR_BITWIDTH-1:0]         w_addr,
    input  logic [LANES*DATA_BITWIDTH-1:0]   w_data,
    input  logic [LANES-1:0]                 w_mask,
    input  logic [ADDR_BITWIDTH-1:0]         r_addr,
    output logic [LANES*DATA_BITWIDTH-1:0]   r_data
);

    localparam logic [ADDR_BITWIDTH:0] DEPTH_W = (ADDR_BITWIDTH + 1)'(DEPTH);

    logic [DATA_BITWIDTH-1:0] mem_r [DEPTH][LANES];
    logic                     w_in_range_s;
    logic                     r_in_range_s;

    // Rows past DEPTH do not exist, so writes to them are silently dropped.
    assign w_in_range_s = ({1'b0, w_addr} < DEPTH_W);
    assign r_in_range_s = ({1'b0, r_addr} < DEPTH_W);

    // Masked per-lane storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we && w_in_range_s && w_mask[l]) begin
                mem_r[w_addr][l] <= w_data[lane_lsb(l, DATA_BITWIDTH) +: DATA_BITWIDTH];
            end
        end
    end

    // Unregistered row read; out-of-range rows read as zero.
    always_comb begin
        r_data = '0;
        if (r_in_range_s) begin
            for (int l = 0; l < LANES; l++) begin
                r_data[lane_lsb(l, DATA_BITWIDTH) +: DATA_BITWIDTH] = mem_r[r_addr][l];
            end
        end else begin
            r_data = '0;
        end
    end

endmodule

// File: rtl/rf_iw_pp_ring.sv
// Ring of NUM_BANK register-file banks: the producer fills w_bank while the consumer drains r_bank.
// Hardware tracks which banks are complete through the w_last and r_release handshakes.
module rf_iw_pp_ring
    import rf_pkg::*;
#(
    parameter int DATA_BITWIDTH = 8,
    parameter int LANES         = 2,
    parameter int DEPTH         = 4,
    parameter int ADDR_BITWIDTH = 2,
    parameter int NUM_BANK      = 2,
    parameter int BANK_BITWIDTH = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             w_en,
    input  logic [ADDR_BITWIDTH-1:0]         w_addr,
    input  logic [LANES*DATA_BITWIDTH-1:0]   w_data,
    input  logic [LANES-1:0]                 w_mask,
    input  logic                             w_last,
    output logic                             w_ready,
    input  logic                             r_en,
    input  logic [ADDR_BITWIDTH-1:0]         r_addr,
    output logic [LANES*DATA_BITWIDTH-1:0]   r_data,
    output logic                             r_valid,
    output logic                             r_avail,
    input  logic                             r_release,
    output logic [BANK_BITWIDTH-1:0]         w_bank,
    output logic [BANK_BITWIDTH-1:0]         r_bank,
    output logic [BANK_BITWIDTH:0]           full_cnt,
    output logic [1:0]                       err
);

    localparam logic [BANK_BITWIDTH-1:0] LAST_BANK = BANK_BITWIDTH'(NUM_BANK - 1);
    localparam logic [BANK_BITWIDTH:0]   CNT_ONE   = (BANK_BITWIDTH + 1)'(1);

    logic [NUM_BANK-1:0]              full_r;
    logic [BANK_BITWIDTH-1:0]         w_bank_r;
    logic [BANK_BITWIDTH-1:0]         r_bank_r;
    logic [BANK_BITWIDTH:0]           full_cnt_r;
    logic [LANES*DATA_BITWIDTH-1:0]   r_data_r;
    logic                             r_valid_r;
    logic [1:0]                       err_r;

    logic                             w_ready_s;
    logic                             r_avail_s;
    logic                             wr_accept_s;
    logic                             fill_done_s;
    logic                             rd_accept_s;
    logic                             rel_accept_s;
    logic [LANES*DATA_BITWIDTH-1:0]   bank_rdata_s [NUM_BANK];

    // Explicit compare rather than a modulo so non-power-of-2 rings wrap correctly.
    function automatic logic [BANK_BITWIDTH-1:0] next_bank(input logic [BANK_BITWIDTH-1:0] b);
        return (b == LAST_BANK) ? {BANK_BITWIDTH{1'b0}} : b + BANK_BITWIDTH'(1);
    endfunction

    assign w_ready_s    = ~full_r[w_bank_r];
    assign r_avail_s    = full_r[r_bank_r];
    assign wr_accept_s  = w_en & w_ready_s;
    assign fill_done_s  = wr_accept_s & w_last;
    assign rd_accept_s  = r_en & r_avail_s;
    assign rel_accept_s = r_release & r_avail_s;

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        rf_bank #(
            .DATA_BITWIDTH(DATA_BITWIDTH),
            .LANES        (LANES),
            .DEPTH        (DEPTH),
            .ADDR_BITWIDTH(ADDR_BITWIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (wr_accept_s && (w_bank_r == BANK_BITWIDTH'(b))),
            .w_addr(w_addr),
            .w_data(w_data),
            .w_mask(w_mask),
            .r_addr(r_addr),
            .r_data(bank_rdata_s[b])
        );
    end

    // Bank ownership: fill and release never hit the same bank, so both updates can apply together.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_r     <= {NUM_BANK{1'b0}};
            w_bank_r   <= {BANK_BITWIDTH{1'b0}};
            r_bank_r   <= {BANK_BITWIDTH{1'b0}};
            full_cnt_r <= {(BANK_BITWIDTH + 1){1'b0}};
        end else begin
            if (fill_done_s) begin
                full_r[w_bank_r] <= 1'b1;
                w_bank_r         <= next_bank(w_bank_r);
            end
            if (rel_accept_s) begin
                full_r[r_bank_r] <= 1'b0;
                r_bank_r         <= next_bank(r_bank_r);
            end
            if (fill_done_s && !rel_accept_s) begin
                full_cnt_r <= full_cnt_r + CNT_ONE;
            end else if (rel_accept_s && !fill_done_s) begin
                full_cnt_r <= full_cnt_r - CNT_ONE;
            end
        end
    end

    // Read register samples the pre-release drain bank, so read+release returns the released data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_r  <= {(LANES * DATA_BITWIDTH){1'b0}};
            r_valid_r <= 1'b0;
        end else if (rd_accept_s) begin
            r_data_r  <= bank_rdata_s[r_bank_r];
            r_valid_r <= 1'b1;
        end else begin
            r_valid_r <= 1'b0;
        end
    end

    // Sticky protocol-violation flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 2'b00;
        end else begin
            err_r[ERR_WR] <= err_r[ERR_WR] | (w_en & ~w_ready_s);
            err_r[ERR_RD] <= err_r[ERR_RD] | ((r_en | r_release) & ~r_avail_s);
        end
    end

    assign w_ready  = w_ready_s;
    assign r_avail  = r_avail_s;
    assign w_bank   = w_bank_r;
    assign r_bank   = r_bank_r;
    assign full_cnt = full_cnt_r;
    assign r_data   = r_data_r;
    assign r_valid  = r_valid_r;
    assign err      = err_r;

endmodule

// File: tb/tb_rf_iw_pp_ring.sv
// Directed self-checking bench for rf_iw_pp_ring: a default 2-bank ring and a 3-bank ring
// share the clock, reset and write data; each has its own handshake strobes.
module tb_rf_iw_pp_ring;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_en, w_last, r_en, r_release;
    logic [1:0]  w_addr, r_addr, w_mask;
    logic [15:0] w_data;
    logic        w_ready, r_valid, r_avail;
    logic [15:0] r_data;
    logic [0:0]  w_bank, r_bank;
    logic [1:0]  full_cnt, err;

    logic        w_en3, w_last3, r_en3, r_release3;
    logic        w_ready3, r_valid3, r_avail3;
    logic [15:0] r_data3;
    logic [1:0]  w_bank3, r_bank3, err3;
    logic [2:0]  full_cnt3;

    int checks = 0;
    int errors = 0;

    rf_iw_pp_ring dut (
        .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .w_mask(w_mask), .w_last(w_last), .w_ready(w_ready), .r_en(r_en), .r_addr(r_addr),
        .r_data(r_data), .r_valid(r_valid), .r_avail(r_avail), .r_release(r_release),
        .w_bank(w_bank), .r_bank(r_bank), .full_cnt(full_cnt), .err(err)
    );

    rf_iw_pp_ring #(
        .DATA_BITWIDTH(8), .LANES(2), .DEPTH(4), .ADDR_BITWIDTH(2), .NUM_BANK(3), .BANK_BITWIDTH(2)
    ) dut3 (
        .clk(clk), .reset(reset), .w_en(w_en3), .w_addr(w_addr), .w_data(w_data),
        .w_mask(w_mask), .w_last(w_last3), .w_ready(w_ready3), .r_en(r_en3), .r_addr(r_addr),
        .r_data(r_data3), .r_valid(r_valid3), .r_avail(r_avail3), .r_release(r_release3),
        .w_bank(w_bank3), .r_bank(r_bank3), .full_cnt(full_cnt3), .err(err3)
    );

    always #5 clk = ~clk;

    // One clock: inputs already set, sample 1ns after the edge, then drop all strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        reset = 1'b0; w_en = 1'b0; w_last = 1'b0; r_en = 1'b0; r_release = 1'b0;
        w_en3 = 1'b0; w_last3 = 1'b0; r_en3 = 1'b0; r_release3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++; if (full_cnt !== 2'd0) begin errors++; $display("FAIL reset_full_cnt: got %0d expected 0", full_cnt); end
        checks++; if (w_bank !== 1'b0 || r_bank !== 1'b0) begin errors++; $display("FAIL reset_banks: got w=%0d r=%0d expected 0 0", w_bank, r_bank); end
        checks++; if (r_data !== 16'h0000 || r_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata: got %h/%b expected 0000/0", r_data, r_valid); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
        checks++; if (w_ready !== 1'b1 || r_avail !== 1'b0) begin errors++; $display("FAIL reset_hs: got w_ready=%b r_avail=%b expected 1 0", w_ready, r_avail); end
        checks++; if (full_cnt3 !== 3'd0 || w_bank3 !== 2'd0 || err3 !== 2'b00) begin errors++; $display("FAIL reset_dut3: got cnt=%0d wb=%0d err=%b expected 0 0 00", full_cnt3, w_bank3, err3); end
    endtask

    task automatic test_wrap3();
        w_addr = 2'd0; r_addr = 2'd0; w_mask = 2'b11;
        for (int i = 0; i < 5; i++) begin
            checks++; if (w_bank3 !== 2'(i % 3)) begin errors++; $display("FAIL wrap_wbank_pre%0d: got %0d expected %0d", i, w_bank3, i % 3); end
            w_en3 = 1'b1; w_last3 = 1'b1; w_data = 16'(i);
            tick();
            checks++; if (w_bank3 !== 2'((i + 1) % 3) || full_cnt3 !== 3'd1 || r_avail3 !== 1'b1) begin errors++; $display("FAIL wrap_fill%0d: got wb=%0d cnt=%0d avail=%b expected %0d 1 1", i, w_bank3, full_cnt3, r_avail3, (i + 1) % 3); end
            r_en3 = 1'b1; r_release3 = 1'b1;
            tick();
            checks++; if (r_data3 !== 16'(i) || r_bank3 !== 2'((i + 1) % 3) || full_cnt3 !== 3'd0) begin errors++; $display("FAIL wrap_drain%0d: got data=%h rb=%0d cnt=%0d expected %h %0d 0", i, r_data3, r_bank3, full_cnt3, 16'(i), (i + 1) % 3); end
        end
        r_release3 = 1'b1;
        tick();
        checks++; if (err3 !== 2'b10 || r_bank3 !== 2'd2) begin errors++; $display("FAIL wrap_empty_release: got err=%b rb=%0d expected 10 2", err3, r_bank3); end
        for (int i = 0; i < 3; i++) begin
            w_en3 = 1'b1; w_last3 = 1'b1; w_data = 16'h00A0;
            tick();
        end
        checks++; if (full_cnt3 !== 3'd3 || w_ready3 !== 1'b0 || w_bank3 !== 2'd2 || r_bank3 !== 2'd2) begin errors++; $display("FAIL wrap_ring_full: got cnt=%0d rdy=%b wb=%0d rb=%0d expected 3 0 2 2", full_cnt3, w_ready3, w_bank3, r_bank3); end
        w_en3 = 1'b1;
        tick();
        checks++; if (err3 !== 2'b11 || full_cnt3 !== 3'd3) begin errors++; $display("FAIL wrap_reject: got err=%b cnt=%0d expected 11 3", err3, full_cnt3); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            w_en = 1'b1; w_addr = 2'(i); w_data = {8'(2 * i + 1), 8'(2 * i)}; w_mask = 2'b11; w_last = (i == 3);
            tick();
        end
        checks++; if (w_bank !== 1'b1 || r_avail !== 1'b1 || full_cnt !== 2'd1 || w_ready !== 1'b1) begin errors++; $display("FAIL fill_status: got wb=%0d avail=%b cnt=%0d rdy=%b expected 1 1 1 1", w_bank, r_avail, full_cnt, w_ready); end
        r_en = 1'b1; r_addr = 2'd2;
        tick();
        checks++; if (r_data !== 16'h0504 || r_valid !== 1'b1) begin errors++; $display("FAIL fill_read: got %h/%b expected 0504/1", r_data, r_valid); end
        tick();
        checks++; if (r_data !== 16'h0504 || r_valid !== 1'b0) begin errors++; $display("FAIL fill_hold: got %h/%b expected 0504/0", r_data, r_valid); end
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 3; i++) begin
            w_en = 1'b1; w_addr = 2'(i); w_data = {8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)}; w_mask = 2'b11;
            r_en = 1'b1; r_addr = 2'(i);
            tick();
            checks++; if (r_data !== {8'(2 * i + 1), 8'(2 * i)}) begin errors++; $display("FAIL overlap_read%0d: got %h expected %h", i, r_data, {8'(2 * i + 1), 8'(2 * i)}); end
        end
        w_en = 1'b1; w_addr = 2'd3; w_data = 16'h1716; w_last = 1'b1; r_release = 1'b1;
        tick();
        checks++; if (full_cnt !== 2'd1 || r_bank !== 1'b1 || w_bank !== 1'b0) begin errors++; $display("FAIL overlap_swap: got cnt=%0d rb=%0d wb=%0d expected 1 1 0", full_cnt, r_bank, w_bank); end
        r_en = 1'b1; r_addr = 2'd0;
        tick();
        checks++; if (r_data !== 16'h1110) begin errors++; $display("FAIL overlap_new0: got %h expected 1110", r_data); end
        r_en = 1'b1; r_addr = 2'd3;
        tick();
        checks++; if (r_data !== 16'h1716 || err !== 2'b00) begin errors++; $display("FAIL overlap_new3: got %h err=%b expected 1716 00", r_data, err); end
    endtask

    task automatic test_ring_full();
        for (int i = 0; i < 4; i++) begin
            w_en = 1'b1; w_addr = 2'(i); w_data = {8'(8'h21 + 2 * i), 8'(8'h20 + 2 * i)}; w_mask = 2'b11; w_last = (i == 3);
            tick();
        end
        checks++; if (full_cnt !== 2'd2 || w_ready !== 1'b0 || w_bank !== 1'b1 || r_avail !== 1'b1) begin errors++; $display("FAIL full_status: got cnt=%0d rdy=%b wb=%0d avail=%b expected 2 0 1 1", full_cnt, w_ready, w_bank, r_avail); end
        w_en = 1'b1; w_addr = 2'd0; w_data = 16'hDEAD; w_mask = 2'b11; w_last = 1'b1;
        tick();
        checks++; if (err !== 2'b01 || full_cnt !== 2'd2 || w_bank !== 1'b1) begin errors++; $display("FAIL full_reject: got err=%b cnt=%0d wb=%0d expected 01 2 1", err, full_cnt, w_bank); end
        r_en = 1'b1; r_addr = 2'd0;
        tick();
        checks++; if (r_data !== 16'h1110) begin errors++; $display("FAIL full_mem_kept: got %h expected 1110", r_data); end
        r_en = 1'b1; r_addr = 2'd1; r_release = 1'b1;
        tick();
        checks++; if (r_data !== 16'h1312 || r_bank !== 1'b0 || full_cnt !== 2'd1 || w_ready !== 1'b1) begin errors++; $display("FAIL read_release: got %h rb=%0d cnt=%0d rdy=%b expected 1312 0 1 1", r_data, r_bank, full_cnt, w_ready); end
    endtask

    task automatic test_masked();
        w_en = 1'b1; w_addr = 2'd0; w_data = 16'h1122; w_mask = 2'b11;
        tick();
        w_en = 1'b1; w_addr = 2'd0; w_data = 16'hAABB; w_mask = 2'b01;
        tick();
        w_en = 1'b1; w_addr = 2'd1; w_data = 16'hFFFF; w_mask = 2'b00; w_last = 1'b1;
        tick();
        checks++; if (full_cnt !== 2'd2) begin errors++; $display("FAIL mask_cnt: got %0d expected 2", full_cnt); end
        r_release = 1'b1;
        tick();
        r_en = 1'b1; r_addr = 2'd0;
        tick();
        checks++; if (r_data !== 16'h11BB || r_bank !== 1'b1) begin errors++; $display("FAIL mask_lane0: got %h rb=%0d expected 11BB 1", r_data, r_bank); end
        r_en = 1'b1; r_addr = 2'd1;
        tick();
        checks++; if (r_data !== 16'h1312) begin errors++; $display("FAIL mask_none: got %h expected 1312", r_data); end
        r_release = 1'b1;
        tick();
        checks++; if (full_cnt !== 2'd0 || r_avail !== 1'b0) begin errors++; $display("FAIL empty_ring: got cnt=%0d avail=%b expected 0 0", full_cnt, r_avail); end
        r_en = 1'b1; r_addr = 2'd0;
        tick();
        checks++; if (err !== 2'b11 || r_valid !== 1'b0 || r_data !== 16'h1312) begin errors++; $display("FAIL empty_read: got err=%b v=%b %h expected 11 0 1312", err, r_valid, r_data); end
    endtask

    task automatic test_reset_mid_fill();
        w_en = 1'b1; w_addr = 2'd0; w_data = 16'h3130; w_mask = 2'b11;
        tick();
        w_en = 1'b1; w_addr = 2'd1; w_data = 16'h3332;
        tick();
        reset = 1'b1; w_en = 1'b1; w_addr = 2'd2; w_data = 16'h3534; w_last = 1'b1;
        tick();
        checks++; if (full_cnt !== 2'd0 || w_bank !== 1'b0 || r_bank !== 1'b0) begin errors++; $display("FAIL midreset_status: got cnt=%0d wb=%0d rb=%0d expected 0 0 0", full_cnt, w_bank, r_bank); end
        checks++; if (r_valid !== 1'b0 || r_data !== 16'h0000 || err !== 2'b00 || w_ready !== 1'b1) begin errors++; $display("FAIL midreset_out: got v=%b %h err=%b rdy=%b expected 0 0000 00 1", r_valid, r_data, err, w_ready); end
        w_en = 1'b1; w_addr = 2'd3; w_data = 16'h3736; w_last = 1'b1;
        tick();
        r_en = 1'b1; r_addr = 2'd0;
        tick();
        checks++; if (r_data !== 16'h3130 || r_valid !== 1'b1) begin errors++; $display("FAIL midreset_mem: got %h/%b expected 3130/1", r_data, r_valid); end
    endtask

    initial begin
        reset = 1'b1; w_en = 1'b0; w_last = 1'b0; r_en = 1'b0; r_release = 1'b0;
        w_en3 = 1'b0; w_last3 = 1'b0; r_en3 = 1'b0; r_release3 = 1'b0;
        w_addr = 2'd0; r_addr = 2'd0; w_mask = 2'b11; w_data = 16'h0000;
        test_reset();
        test_wrap3();
        test_fill();
        test_overlap();
        test_ring_full();
        test_masked();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/rf_iw_pp_ring.md
Name: rf_iw_pp_ring

Overview:
- Parametrised successor to the activation/weight dual-port double-buffer RF.
- Generalises the manual write_sel ping-pong into a ring of NUM_BANK banks, each LANES words wide.
- The global-buffer side fills one bank while the MAC side reads another.
- Bank ownership is tracked by hardware with ready/release handshakes, so the controller no longer toggles a select line.

Parameters:
- DATA_BITWIDTH, 8, bits per lane word
- LANES, 2, words per row, written and read in parallel
- DEPTH, 4, rows per bank
- ADDR_BITWIDTH, 2, row address width; must be >= clog2(DEPTH)
- NUM_BANK, 2, banks in the ring; must be >= 2
- BANK_BITWIDTH, 1, bank index width; must be >= clog2(NUM_BANK)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset, sampled on posedge clk
- w_en  in  1  write request
- w_addr  in  ADDR_BITWIDTH  write row
- w_data  in  LANES*DATA_BITWIDTH  write row data; lane 0 in the LSBs
- w_mask  in  LANES  per-lane write enable
- w_last  in  1  with an accepted w_en, marks the fill bank complete
- w_ready  out  1  the fill bank is free to write
- r_en  in  1  read request
- r_addr  in  ADDR_BITWIDTH  read row
- r_data  out  LANES*DATA_BITWIDTH  registered read data
- r_valid  out  1  r_data updated this cycle
- r_avail  out  1  the drain bank holds complete data
- r_release  in  1  consumer has finished with the drain bank
- w_bank  out  BANK_BITWIDTH  current fill bank index
- r_bank  out  BANK_BITWIDTH  current drain bank index
- full_cnt  out  BANK_BITWIDTH+1  number of complete banks
- err  out  2  sticky errors: [0] write while !w_ready, [1] read/release while !r_avail

Behaviour:
- Reset (synchronous):
  - full[] all 0; w_bank = r_bank = 0; full_cnt = 0
  - r_data = 0, r_valid = 0, err = 0
  - Memory contents are not cleared.
  - Reset asserted mid-fill or mid-drain discards all bank status on that edge.
- Combinational outputs:
  - w_ready = !full[w_bank]
  - r_avail = full[r_bank]
- Write acceptance:
  - A write is accepted when w_en && w_ready.
  - Each lane l with w_mask[l] = 1 writes mem[w_bank][w_addr][l].
  - w_addr >= DEPTH: data is dropped; the handshake still counts.
- Fill completion: an accepted write with w_last sets full[w_bank] and advances w_bank = (w_bank+1) mod NUM_BANK.
  - w_last without w_en does nothing.
- Rejected write: w_en && !w_ready changes no state and sets err[0].
- Read (1-cycle latency):
  - r_en && r_avail: at the next edge r_data <= mem[r_bank][r_addr] and r_valid <= 1.
  - r_addr >= DEPTH returns 0.
  - Otherwise r_valid <= 0 and r_data holds its value.
  - r_en while !r_avail sets err[1].
- Release:
  - r_release && r_avail clears full[r_bank] and advances r_bank mod NUM_BANK.
  - r_release while !r_avail sets err[1] and changes no state.
- Read and release in the same cycle: the read returns data from the bank being released, i.e. the pre-release r_bank.
- Fill completion and release in the same cycle:
  - They always target different banks: fill needs full[w_bank] = 0 and release needs full[r_bank] = 1.
  - Both take effect; full_cnt is unchanged.
- full_cnt: increments on fill completion, decrements on release, and is unchanged when both occur together. Range is 0..NUM_BANK.
- Ring full: full_cnt == NUM_BANK, so w_bank == r_bank and w_ready = 0.
- Ring empty: full_cnt == 0, so r_avail = 0.
- Wrap-around: both indices wrap at NUM_BANK-1 to 0. This must hold for non-power-of-2 NUM_BANK.
- Same-bank write/read cannot occur, because ownership is exclusive by construction.

Decomposition:
- Package rf_pkg:
  - clog2 function
  - lane slice helper constants (LANE_LSB(l) = l*DATA_BITWIDTH)
  - error bit index constants ERR_WR = 0, ERR_RD = 1
- Sub-module rf_bank: one bank with DEPTH x LANES, masked synchronous write and an unregistered read mux.
  - The top level instantiates NUM_BANK of them via generate.
  - The top level holds the full[] vector, both ring pointers, full_cnt, the output register and error logic.

Test Plan (DATA_BITWIDTH=8, LANES=2, DEPTH=4, NUM_BANK=2 unless noted):
- Fill bank 0 rows 0..3 with 0x0100, 0x0302, 0x0504, 0x0706 (w_last on row 3), mask 2'b11:
  - w_bank -> 1, r_avail = 1, full_cnt = 1
  - r_en addr 2 -> one cycle later r_data = 0x0504, r_valid = 1.
- Overlap: fill bank 1 while reading bank 0, then release bank 0 in the same cycle as bank 1's w_last:
  - full_cnt stays 1
  - r_bank = 1, w_bank = 0
  - reading bank 1 returns the new data.
- Fill both banks without release:
  - w_ready = 0, full_cnt = 2
  - a further w_en sets err[0] and memory is unchanged (verify by read).
- Masked write 0xAABB with w_mask = 2'b01 over a row holding 0x1122 -> row reads 0x11BB.
- NUM_BANK=3: fill/release 5 times -> indices wrap 0,1,2,0,1; r_release with an empty ring sets err[1].
- Assert reset mid-fill (bank 0 half written):
  - next cycle full_cnt = 0, w_bank = 0, r_valid = 0, r_data = 0, err = 0, w_ready = 1.
